fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
- Initiator side of the FIR sample handshake. Buffers incoming samples in a small FIFO and issues one single-cycle inputValid strobe per sample to the FIR core.
- Waits for the core's outputValid before issuing the next sample. Captures the filtered result and presents it downstream as a one-cycle result strobe.
- Sits between the sample source (ADC/testbench stream) and the FIR top, serialising bursty input into the core's one-sample-per-computation cadence.

Parameters:
- InputWidth, 16, sample width driven to the FIR core.
- OutputWidth, 38, FIR result width captured from the core.
- FifoDepth, 16, sample FIFO entries (power of two, >= 2).
- TimeoutCycles, 255, max WAIT cycles before declaring a stalled core (must be > FIR_size + 2; FIR_size = 64).
- CountWidth, 16, width of the completed-sample counter.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  source sample valid.
- in_data  input  InputWidth  source sample.
- in_ready  output  1  FIFO can accept (= !full).
- fir_inputValid  output  1  one-cycle strobe to FIR inputValid.
- fir_input  output  InputWidth  sample to FIR_input, registered, held stable until next issue.
- fir_outputValid  input  1  FIR outputValid.
- fir_output  input  OutputWidth  FIR_output.
- result_valid  output  1  one-cycle strobe, result captured.
- result_data  output  OutputWidth  captured FIR result, held until next capture.
- sample_count  output  CountWidth  completed samples, wraps modulo 2^CountWidth.
- timeout_err  output  1  sticky: core failed to answer within TimeoutCycles.
- busy  output  1  high in ISSUE or WAIT.

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - FIFO emptied; state=IDLE; wait counter=0.
  - All outputs 0, except in_ready=1 the cycle after reset.
  - Reset mid-WAIT abandons the in-flight sample. A late fir_outputValid after reset is ignored.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - No bypass: a sample pushed into an empty FIFO is popped no earlier than the next cycle.
  - When full, in_ready=0 and in_valid is ignored (no overwrite).
- FSM, three states:
  - IDLE:
    - If FIFO non-empty: pop, load fir_input with the head entry, go to ISSUE.
    - Otherwise stay.
  - ISSUE:
    - fir_inputValid=1 for exactly this cycle.
    - Clear wait counter, go to WAIT.
  - WAIT:
    - Increment wait counter each cycle.
    - If fir_outputValid=1: capture fir_output into result_data, assert result_valid on the next cycle for 1 cycle, increment sample_count, go to IDLE.
    - Else if wait counter == TimeoutCycles: set timeout_err (sticky until rst), go to IDLE. No result, no count increment.
    - fir_outputValid and timeout in the same cycle: the result wins.
- fir_outputValid in IDLE or ISSUE is ignored (no capture, no count).
- Latency from a non-empty FIFO in IDLE:
  - fir_inputValid asserts 1 cycle later.
  - Minimum issue-to-issue spacing = core latency + 2 cycles (WAIT->IDLE->ISSUE).
- fir_inputValid never asserts twice without an intervening fir_outputValid or timeout.
- busy = (state != IDLE).
- result_data and fir_input are plain registers. No arithmetic besides counters; counters wrap silently.

Test Plan:
- Single sample: push 0x1234. fir_inputValid pulses 2 cycles after the push with fir_input=0x1234. Model core answers 0x00_0000_1234 after 66 cycles. result_valid pulses once with that value; sample_count=1.
- Burst: push 20 samples back-to-back (in_valid held high).
  - in_ready drops after 16 accepted (plus the ones popped meanwhile) and source stalls correctly.
  - All 20 issued in order, each only after the previous outputValid.
  - sample_count=20 and no timeout_err.
- Stalled core: push 1 sample and never assert fir_outputValid. timeout_err rises exactly 255 WAIT cycles after ISSUE. FSM returns to IDLE and issues the next queued sample; timeout_err stays 1.
- Spurious/simultaneous:
  - fir_outputValid pulsed while IDLE: no result_valid, count unchanged.
  - fir_outputValid on the exact timeout cycle: result captured, timeout_err stays 0.
- Reset mid-WAIT: assert rst 10 cycles into WAIT with 3 samples queued.
  - Next cycle: all outputs 0, FIFO empty, in_ready=1.
  - Core's later outputValid produces no result_valid.
- Counter wrap: with CountWidth=4, complete 17 samples. sample_count reads 1.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Initiator side of the FIR sample handshake. Samples from a bursty source
//   are buffered in a small FIFO and handed to the FIR core one at a time:
//   each sample gets a single-cycle fir_inputValid strobe, and the next
//   sample is only issued after the core answers with fir_outputValid (or
//   after a timeout declares the core stalled). Each answer is captured and
//   presented downstream as a one-cycle result strobe.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/in_data source sample stream; in_ready = FIFO not full
//   fir_inputValid   one-cycle issue strobe to the core
//   fir_input        issued sample, held until the next issue
//   fir_outputValid  core answer strobe; fir_output = core result
//   result_valid     one-cycle strobe after a capture; result_data held
//   sample_count     completed samples, wraps modulo 2^CountWidth
//   timeout_err      sticky: core did not answer within TimeoutCycles
//   busy             FSM is in ISSUE or WAIT
module fir_sample_feeder #(
  parameter int InputWidth    = 16,
  parameter int OutputWidth   = 38,
  parameter int FifoDepth     = 16,
  parameter int TimeoutCycles = 255,
  parameter int CountWidth    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [InputWidth-1:0]  in_data,
  output logic                   in_ready,
  output logic                   fir_inputValid,
  output logic [InputWidth-1:0]  fir_input,
  input  logic                   fir_outputValid,
  input  logic [OutputWidth-1:0] fir_output,
  output logic                   result_valid,
  output logic [OutputWidth-1:0] result_data,
  output logic [CountWidth-1:0]  sample_count,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int AW = $clog2(FifoDepth);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [AW:0]   FullCnt = (AW+1)'(FifoDepth);
  localparam logic [TW-1:0] ToLimit = TW'(TimeoutCycles);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // ---------------- sample FIFO ----------------
  logic [InputWidth-1:0] r_mem [FifoDepth];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;

  state_t                r_state;
  logic [TW-1:0]         r_wait_cnt;
  logic                  r_fir_valid;
  logic [InputWidth-1:0] r_fir_input;
  logic                  r_res_valid;
  logic [OutputWidth-1:0] r_res_data;
  logic [CountWidth-1:0] r_sample_count;
  logic                  r_timeout;

  logic          w_full, w_empty, w_push, w_pop, w_timeout;
  logic [TW-1:0] w_wait_nxt;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  // Pop only on the IDLE->ISSUE transition; the head is read from memory,
  // so a sample written this cycle is not visible until the next one.
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // ---------------- handshake FSM ----------------
  // The timeout compares the post-increment value, so it fires on the
  // TimeoutCycles-th WAIT cycle counted from 1.
  assign w_wait_nxt = r_wait_cnt + 1'b1;
  assign w_timeout  = (w_wait_nxt == ToLimit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_fir_valid    <= 1'b0;
      r_fir_input    <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_sample_count <= '0;
      r_timeout      <= 1'b0;
    end else begin
      r_fir_valid <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_fir_input <= r_mem[r_rd_ptr];
            r_fir_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= w_wait_nxt;
          // An answer on the timeout cycle still counts as a result.
          if (fir_outputValid) begin
            r_res_data     <= fir_output;
            r_res_valid    <= 1'b1;
            r_sample_count <= r_sample_count + 1'b1;
            r_state        <= S_IDLE;
          end else if (w_timeout) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = !w_full;
  assign fir_inputValid = r_fir_valid;
  assign fir_input      = r_fir_input;
  assign result_valid   = r_res_valid;
  assign result_data    = r_res_data;
  assign sample_count   = r_sample_count;
  assign timeout_err    = r_timeout;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: a transaction-level model (sample queue,
// occupancy count, outstanding-request flag, wait-cycle count) plus a model
// FIR core with programmable latency run alongside the DUT, and directed
// phases drive the scenarios. CountWidth is 4 so the counter wraps.
module tb_fir_sample_feeder;
  localparam int IW = 16, OW = 38, DEPTH = 16, TO = 255, CW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, fir_outputValid;
  logic [IW-1:0] in_data;
  logic [OW-1:0] fir_output;
  logic in_ready, fir_inputValid, result_valid, timeout_err, busy;
  logic [IW-1:0] fir_input;
  logic [OW-1:0] result_data;
  logic [CW-1:0] sample_count;

  fir_sample_feeder #(.InputWidth(IW), .OutputWidth(OW), .FifoDepth(DEPTH),
                      .TimeoutCycles(TO), .CountWidth(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fir_inputValid(fir_inputValid), .fir_input(fir_input),
    .fir_outputValid(fir_outputValid), .fir_output(fir_output),
    .result_valid(result_valid), .result_data(result_data),
    .sample_count(sample_count), .timeout_err(timeout_err), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model + model core ----------------
  logic [IW-1:0] sample_q[$];
  int occ = 0, exp_count = 0, cyc = 0, wait_n = 0, core_cnt = 0, lat = 10;
  bit outstanding = 0, exp_to = 0, started = 0, saw_full = 0;
  bit p_rst = 0, p_push = 0, p_fire = 0, p_timeout = 0;
  bit core_en = 1, spur = 0, rand_resp = 1;
  logic [IW-1:0] p_push_data = '0, last_issued = '0;
  logic [OW-1:0] p_fire_data = '0;

  initial begin
    bit fire;
    logic [63:0] r64;
    fir_outputValid = 1'b0;
    fir_output = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (started) begin
        if (p_rst) begin
          sample_q.delete();
          occ = 0; outstanding = 0; exp_to = 0; exp_count = 0;
          p_fire = 0; p_timeout = 0;
          chk("rst_fir_input", fir_input, 0);
          chk("rst_result_data", result_data, 0);
          chk("rst_sample_count", sample_count, 0);
        end else if (p_push) begin
          occ++;
          sample_q.push_back(p_push_data);
        end
        if (fir_inputValid) begin
          chk("issue_while_outstanding", outstanding, 0);
          if (sample_q.size() == 0) chk("issue_from_empty", fir_inputValid, 0);
          else chk("issue_order", fir_input, sample_q.pop_front());
          occ--;
          outstanding = 1; wait_n = 0; last_issued = fir_input;
        end
        chk("in_ready", in_ready, occ < DEPTH);
        if (!in_ready) saw_full = 1;
        chk("busy", busy, outstanding);
        chk("result_valid", result_valid, p_fire);
        if (p_fire) begin
          exp_count++;
          chk("result_data", result_data, p_fire_data);
          chk("sample_count", sample_count, exp_count % (1 << CW));
        end
        if (p_timeout) exp_to = 1;
        chk("timeout_err", timeout_err, exp_to);
        p_fire = 0; p_timeout = 0;

        // model core: answers `lat` cycles after seeing the issue strobe
        fire = 0;
        fir_outputValid = 1'b0;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) fire = 1;
        end
        if (spur) begin fire = 1; spur = 0; end
        if (fire) begin
          r64 = {$urandom, $urandom};
          fir_output = rand_resp ? r64[OW-1:0] : OW'(last_issued);
          fir_outputValid = 1'b1;
        end
        // a WAIT cycle: the answer wins over the timeout
        if (outstanding && !fir_inputValid) begin
          wait_n++;
          if (fire) begin p_fire = 1; p_fire_data = fir_output; outstanding = 0; end
          else if (wait_n == TO) begin p_timeout = 1; outstanding = 0; end
        end
        if (fir_inputValid && core_en) core_cnt = lat;
        p_push = in_valid && in_ready;
        p_push_data = in_data;
      end
      started |= rst;
      p_rst = rst;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [IW-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 3000) begin tick(); n++; end
    chk("push_accepted", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    tick();
    while ((sample_q.size() != 0 || outstanding || core_cnt != 0) && n < 8000) begin
      tick(); n++;
    end
    chk("drain_done", busy, 0);
    repeat (3) tick();
  endtask

  task automatic wait_issue(output int c);
    int n = 0;
    while (!fir_inputValid && n < 500) begin tick(); n++; end
    chk("issue_seen", fir_inputValid, 1);
    c = cyc;
  endtask

  initial begin
    int ic, tc, n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_fir_inputValid", fir_inputValid, 0);

    // single sample, latency from push to issue, core answers after 66
    rand_resp = 0; lat = 66;
    in_valid = 1'b1; in_data = 16'h1234;
    tick(); in_valid = 1'b0;
    chk("single_no_bypass", fir_inputValid, 0);
    tick();
    chk("single_issue_strobe", fir_inputValid, 1);
    chk("single_issue_data", fir_input, 16'h1234);
    n = 0;
    while (!result_valid && n < 200) begin tick(); n++; end
    chk("single_result_valid", result_valid, 1);
    chk("single_result_data", result_data, 38'h00_0000_1234);
    chk("single_count", sample_count, 1);
    tick();
    chk("single_result_one_cycle", result_valid, 0);
    rand_resp = 1;

    // burst of 20 back-to-back samples, random core latency
    saw_full = 0;
    for (int i = 0; i < 20; i++) begin
      lat = $urandom_range(40, 5);
      push(IW'($urandom));
    end
    wait_drain();
    chk("burst_fifo_filled", saw_full, 1);
    chk("burst_count", sample_count, 21 % 16);
    chk("burst_no_timeout", timeout_err, 0);

    // spurious answer while idle
    spur = 1;
    repeat (4) tick();
    chk("spurious_count", sample_count, 21 % 16);

    // answer lands on the timeout cycle itself
    lat = TO;
    push(16'hbeef);
    wait_drain();
    chk("simul_no_timeout", timeout_err, 0);
    chk("simul_count", sample_count, 22 % 16);

    // stalled core: first sample times out, second is then served
    core_en = 0; lat = 12;
    push(16'h0a0a);
    push(16'h0b0b);
    wait_issue(ic);
    n = 0;
    while (!timeout_err && n < 400) begin tick(); n++; end
    tc = cyc;
    chk("stall_timeout_set", timeout_err, 1);
    chk("stall_wait_cycles", tc - ic - 1, 255);
    core_en = 1;
    wait_drain();
    chk("stall_sticky", timeout_err, 1);
    chk("stall_count", sample_count, 23 % 16);

    // reset in the middle of WAIT with samples queued
    lat = 100;
    for (int i = 0; i < 4; i++) push(IW'($urandom));
    wait_issue(ic);
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_timeout", timeout_err, 0);
    chk("midrst_fir_inputValid", fir_inputValid, 0);
    wait_drain();
    chk("midrst_late_answer_ignored", sample_count, 0);

    // counter wrap: 17 completions with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      lat = $urandom_range(8, 1);
      push(IW'($urandom));
    end
    wait_drain();
    chk("wrap_count", sample_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
